// File: rtl/pgen_pkg.sv
// Shared state encodings and polarity helper for the pgen_v2 pulse-train generator.
package pgen_pkg;

    typedef logic [1:0] pgen_state_t;

    localparam pgen_state_t IDLE = 2'b00;
    localparam pgen_state_t HIGH = 2'b01;
    localparam pgen_state_t LOW  = 2'b10;
    localparam pgen_state_t DONE = 2'b11;

    // Inactive level of the pulse output for a given polarity.
    function automatic logic idle_level(input bit act_high);
        return !act_high;
    endfunction

endpackage

// File: rtl/pgen_phase_cnt.sv
// Loadable down-counter timing one HIGH or LOW phase; saturates at zero.
module pgen_phase_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pgen_v2.sv
// Programmable pulse-train generator: latches period/high time/count on start and emits
// that many pulses (or runs continuously for a count of 0) until done or stopped.
module pgen_v2
    import pgen_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned NUM_W    = 8,
    parameter bit          ACT_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic [1:0]       PS,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NUM_W-1:0] pulse_cnt
);

    pgen_state_t      state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic             ph_load, ph_en, ph_zero;
    logic [CNT_W-1:0] ph_val, ph_cnt;
    logic             cfg_ok, req, launch, reject, last_pulse;
    logic [NUM_W-1:0] cnt_inc;

    assign cfg_ok     = (high_len != '0) && (period > high_len);
    assign req        = (state_q == IDLE) && start && !stop;
    assign launch     = req && cfg_ok;
    assign reject     = req && !cfg_ok;
    assign cnt_inc    = pulse_cnt_q + NUM_W'(1);
    assign last_pulse = (num_q != '0) && (cnt_inc == num_q);

    pgen_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (ph_en),
        .cnt      (ph_cnt),
        .zero     (ph_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (launch) state_d = HIGH;
            HIGH: begin
                if (stop) state_d = IDLE;
                else if (ph_zero) state_d = LOW;
            end
            LOW: begin
                if (stop) state_d = IDLE;
                else if (ph_zero) state_d = last_pulse ? DONE : HIGH;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter control and config/pulse-count datapath.
    always_comb begin
        ph_load     = 1'b0;
        ph_en       = 1'b0;
        ph_val      = '0;
        period_d    = period_q;
        high_d      = high_q;
        num_d       = num_q;
        pulse_cnt_d = pulse_cnt_q;
        cfg_err_d   = reject;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    ph_load     = 1'b1;
                    ph_val      = high_len - CNT_W'(1);
                    period_d    = period;
                    high_d      = high_len;
                    num_d       = num_pulses;
                    pulse_cnt_d = '0;
                end
            end
            HIGH: begin
                if (!stop) begin
                    if (ph_zero) begin
                        ph_load = 1'b1;
                        ph_val  = period_q - high_q - CNT_W'(1);
                    end else begin
                        ph_en = 1'b1;
                    end
                end
            end
            LOW: begin
                if (!stop) begin
                    if (ph_zero) begin
                        pulse_cnt_d = cnt_inc;
                        ph_load     = !last_pulse;
                        ph_val      = high_q - CNT_W'(1);
                    end else begin
                        ph_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q    <= '0;
            high_q      <= '0;
            num_q       <= '0;
            pulse_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            period_q    <= period_d;
            high_q      <= high_d;
            num_q       <= num_d;
            pulse_cnt_q <= pulse_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        PS        = state_q;
        pulse     = (state_q == HIGH) ? ACT_HIGH : idle_level(ACT_HIGH);
        busy      = (state_q == HIGH) || (state_q == LOW);
        done      = (state_q == DONE);
        cfg_err   = cfg_err_q;
        pulse_cnt = pulse_cnt_q;
    end

endmodule
